// File: rtl/mul_hilo_ctrl.sv
// Sequencer for an external 32x32 combinational multiplier with MIPS-style HI/LO result registers.
// Operands are registered, held for SETTLE_CYCLES, then the 64-bit product is captured into HI/LO.
module mul_hilo_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] operand_m,
    input  logic [31:0] operand_q,
    output logic [31:0] mult_m,
    output logic [31:0] mult_q,
    input  logic [63:0] mult_product,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        hi_wr,
    input  logic        lo_wr
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSettle  = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;

    localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mult_m_q, mult_m_d;
    logic [31:0] mult_q_q, mult_q_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mult_m_d = mult_m_q;
        mult_q_d = mult_q_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (hi_wr) hi_d = hi_in;
                if (lo_wr) lo_d = lo_in;
                if (start) begin
                    mult_m_d = operand_m;
                    mult_q_d = operand_q;
                    cnt_d    = CntInit;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (hi_wr) hi_d = hi_in;
                if (lo_wr) lo_d = lo_in;
                if (cnt_q == 4'd0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCapture: begin
                // Product capture takes priority; any external HI/LO write this cycle is dropped.
                hi_d    = mult_product[63:32];
                lo_d    = mult_product[31:0];
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            mult_m_q <= 32'd0;
            mult_q_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mult_m_q <= mult_m_d;
            mult_q_q <= mult_q_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign mult_m = mult_m_q;
    assign mult_q = mult_q_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign done   = done_q;
    assign busy   = (state_q == StSettle) || (state_q == StCapture);

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Scoreboard bench for mul_hilo_ctrl: main instance at SETTLE_CYCLES=2, plus 1 and 15 for latency.
module tb_mul_hilo_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [31:0] operand_m, operand_q, hi_in, lo_in;
    logic        hi_wr, lo_wr;
    logic        start0, start1, start15;

    logic [31:0] m0, q0, hi0, lo0, m1, q1, hi1, lo1, m15, q15, hi15, lo15;
    logic [63:0] p0, p1, p15;
    logic        busy0, done0, busy1, done1, busy15, done15;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c, d1, d15;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // Reference signed 32x32 -> 64 multiplier standing in for the downstream unit.
    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        x = longint'({{32{a[31]}}, a});
        y = longint'({{32{b[31]}}, b});
        return 64'(x * y);
    endfunction

    assign p0  = smul(m0, q0);
    assign p1  = smul(m1, q1);
    assign p15 = smul(m15, q15);

    mul_hilo_ctrl #(.SETTLE_CYCLES(2)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .start(start0),
        .operand_m(operand_m), .operand_q(operand_q),
        .mult_m(m0), .mult_q(q0), .mult_product(p0),
        .busy(busy0), .done(done0), .hi(hi0), .lo(lo0),
        .hi_in(hi_in), .lo_in(lo_in), .hi_wr(hi_wr), .lo_wr(lo_wr)
    );

    mul_hilo_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1),
        .operand_m(operand_m), .operand_q(operand_q),
        .mult_m(m1), .mult_q(q1), .mult_product(p1),
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1),
        .hi_in(hi_in), .lo_in(lo_in), .hi_wr(hi_wr), .lo_wr(lo_wr)
    );

    mul_hilo_ctrl #(.SETTLE_CYCLES(15)) u_dut15 (
        .clock(clock), .reset_n(reset_n), .start(start15),
        .operand_m(operand_m), .operand_q(operand_q),
        .mult_m(m15), .mult_q(q15), .mult_product(p15),
        .busy(busy15), .done(done15), .hi(hi15), .lo(lo15),
        .hi_in(hi_in), .lo_in(lo_in), .hi_wr(hi_wr), .lo_wr(lo_wr)
    );

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; done is expected SETTLE_CYCLES+2 counted edges later.
    task automatic issue(input logic [31:0] m, input logic [31:0] q);
        exp_t        e;
        logic [63:0] p;
        p         = smul(m, q);
        operand_m = m;
        operand_q = q;
        start0    = 1'b1;
        e.hi      = p[63:32];
        e.lo      = p[31:0];
        e.cyc     = cyc + 2 + 2;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            check("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (done0) begin
            if (sb.size() == 0) begin
                check("done_unexpected", 64'(done0), 64'd0);
            end else begin
                e = sb.pop_front();
                check("res_hi", 64'(hi0), 64'(e.hi));
                check("res_lo", 64'(lo0), 64'(e.lo));
                check("done_cyc", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        operand_m = $urandom; operand_q = $urandom;
        hi_in     = $urandom; lo_in     = $urandom;
        hi_wr     = 1'b1;     lo_wr     = 1'b1;
        start0    = 1'b1;     start1    = 1'b1; start15 = 1'b1;
        @(negedge clock);
        operand_m = $urandom; operand_q = $urandom;
        hi_in     = $urandom; lo_in     = $urandom;
        @(negedge clock);
        check("rst_hi", 64'(hi0), 64'd0);
        check("rst_lo", 64'(lo0), 64'd0);
        check("rst_mult_m", 64'(m0), 64'd0);
        check("rst_mult_q", 64'(q0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_busy15", 64'(busy15), 64'd0);
        reset_n = 1'b1;
        start0  = 1'b0; start1 = 1'b0; start15 = 1'b0;
        hi_wr   = 1'b0; lo_wr  = 1'b0;

        // Basic 3 x 5
        @(negedge clock);
        issue(32'd3, 32'd5);
        @(negedge clock);
        start0 = 1'b0;
        check("basic_busy1", 64'(busy0), 64'd1);
        check("basic_mult_m", 64'(m0), 64'd3);
        check("basic_mult_q", 64'(q0), 64'd5);
        @(negedge clock);
        check("basic_busy2", 64'(busy0), 64'd1);
        @(negedge clock);
        check("basic_busy3", 64'(busy0), 64'd1);
        @(negedge clock);
        check("basic_busy_end", 64'(busy0), 64'd0);
        check("basic_done", 64'(done0), 64'd1);
        check("basic_lo", 64'(lo0), 64'd15);
        @(negedge clock);
        check("done_one_cycle", 64'(done0), 64'd0);
        wait_idle();

        // Signed: -2 x 3
        @(negedge clock);
        issue(32'hFFFF_FFFE, 32'd3);
        @(negedge clock);
        start0 = 1'b0;
        wait_idle();
        check("signed_hi", 64'(hi0), 64'hFFFF_FFFF);
        check("signed_lo", 64'(lo0), 64'hFFFF_FFFA);

        // Start while busy is ignored; start in done cycle is accepted
        @(negedge clock);
        issue(32'd10, 32'd20);
        @(negedge clock);
        operand_m = 32'd7; operand_q = 32'd9; start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        check("ignored_mult_m", 64'(m0), 64'd10);
        check("ignored_mult_q", 64'(q0), 64'd20);
        @(negedge clock);
        check("capture_busy", 64'(busy0), 64'd1);
        @(negedge clock);
        check("b2b_done", 64'(done0), 64'd1);
        issue(32'd2, 32'd4);
        @(negedge clock);
        start0 = 1'b0;
        check("b2b_mult_m", 64'(m0), 64'd2);
        wait_idle();
        check("b2b_lo", 64'(lo0), 64'd8);

        // HI/LO writes vs. start and capture
        @(negedge clock);
        issue(32'h0001_0000, 32'h0003_0000);
        lo_wr = 1'b1; lo_in = 32'hCAFE_F00D;
        @(negedge clock);
        start0 = 1'b0; lo_wr = 1'b0;
        check("wr_with_start_lo", 64'(lo0), 64'hCAFE_F00D);
        check("start_with_wr_m", 64'(m0), 64'h0001_0000);
        hi_wr = 1'b1; hi_in = 32'hAAAA_5555;
        @(negedge clock);
        hi_wr = 1'b0;
        check("settle_hi_wr", 64'(hi0), 64'hAAAA_5555);
        @(negedge clock);
        hi_wr = 1'b1; hi_in = 32'hDEAD_BEEF;
        @(negedge clock);
        hi_wr = 1'b0;
        check("capture_wins_hi", 64'(hi0), 64'd3);
        lo_wr = 1'b1; lo_in = 32'h1234_5678;
        @(negedge clock);
        lo_wr = 1'b0;
        check("idle_lo_wr", 64'(lo0), 64'h1234_5678);
        wait_idle();

        // Random operands, back to back
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            issue($urandom, $urandom);
            @(negedge clock);
            start0 = 1'b0;
            wait_idle();
        end

        // Abort by reset mid-SETTLE
        @(negedge clock);
        issue(32'd6, 32'd7);
        @(negedge clock);
        start0 = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        check("abort_busy", 64'(busy0), 64'd0);
        check("abort_done", 64'(done0), 64'd0);
        check("abort_hi", 64'(hi0), 64'd0);
        check("abort_lo", 64'(lo0), 64'd0);
        repeat (6) @(negedge clock);
        check("abort_no_done", 64'(done0), 64'd0);
        check("abort_lo_held", 64'(lo0), 64'd0);

        // Latency at SETTLE_CYCLES = 1 and 15
        @(negedge clock);
        operand_m = 32'd9; operand_q = 32'd11;
        start1 = 1'b1; start15 = 1'b1;
        c = cyc; d1 = -1; d15 = -1;
        @(negedge clock);
        start1 = 1'b0; start15 = 1'b0;
        for (int i = 0; i < 40 && (d1 < 0 || d15 < 0); i++) begin
            if (done1 && d1 < 0) d1 = cyc;
            if (done15 && d15 < 0) d15 = cyc;
            @(negedge clock);
        end
        check("latency_sc1", 64'(d1 - (c + 1)), 64'd2);
        check("latency_sc15", 64'(d15 - (c + 1)), 64'd16);
        check("sc1_lo", 64'(lo1), 64'd99);
        check("sc15_lo", 64'(lo15), 64'd99);
        check("sc15_hi", 64'(hi15), 64'd0);

        @(negedge clock);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
